// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int HZ_CNT_W   = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LU_STALL = 2'b01,
    MC_BUSY  = 2'b10,
    FLUSH    = 2'b11
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Operand forwarding select for one EX source: the MEM producer beats WB.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_reg_wr,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_wr,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hardwired, so it can never be a forwarding source.
  assign mem_hit = mem_reg_wr && (src_addr != '0) && (src_addr == mem_rd_addr);
  assign wb_hit  = wb_reg_wr  && (src_addr != '0) && (src_addr == wb_rd_addr);

  // Youngest producer wins.
  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for a 5-stage pipeline: forwarding selects, load-use and
// multi-cycle stalls, post-branch flushes and a saturating stall counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_ex_rs1_addr,
  input  logic [REG_AW-1:0] i_ex_rs2_addr,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic              i_ex_reg_wr,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_reg_wr,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic              i_wb_reg_wr,
  input  logic              i_br_tk,
  input  logic              i_mc_start,
  input  logic              i_mc_done,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_stall,
  output logic              o_bubble,
  output logic              o_flush,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  // Counter reload values: the detection cycle itself is the first cycle.
  localparam logic [HZ_CNT_W-1:0] LU_RELOAD = HZ_CNT_W'(LOAD_LAT - 1);
  localparam logic [HZ_CNT_W-1:0] FL_RELOAD = HZ_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e           state_reg;
  hz_state_e           state_next;
  logic [HZ_CNT_W-1:0] cnt_reg;
  logic [HZ_CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0]    stall_cnt_reg;
  logic                stall_c;
  logic                bubble_c;
  logic                flush_c;
  logic                lu_hz;

  logic [REG_AW-1:0] ex_src [2];
  logic [1:0]        fwd_raw [2];

  assign ex_src[0] = i_ex_rs1_addr;
  assign ex_src[1] = i_ex_rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
      .src_addr    (ex_src[gi]),
      .mem_rd_addr (i_mem_rd_addr),
      .mem_reg_wr  (i_mem_reg_wr),
      .wb_rd_addr  (i_wb_rd_addr),
      .wb_reg_wr   (i_wb_reg_wr),
      .sel         (fwd_raw[gi])
    );
  end

  // A load in EX whose result is needed by the instruction in ID.
  assign lu_hz = i_ex_is_load && i_ex_reg_wr && (i_ex_rd_addr != '0) &&
                 ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                  (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  // Next state and first-cycle outputs; the detection cycle is combinational.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_br_tk) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            cnt_next   = FL_RELOAD;
          end
        end else if (i_mc_start) begin
          stall_c = 1'b1;
          if (!i_mc_done) begin
            state_next = MC_BUSY;
          end
        end else if (lu_hz) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_next = LU_STALL;
            cnt_next   = LU_RELOAD;
          end
        end
      end
      LU_STALL: begin
        if (i_br_tk) begin
          // The branch squashes the stalled instruction, so flushing replaces stalling.
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            cnt_next   = FL_RELOAD;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == HZ_CNT_W'(1)) begin
            state_next = IDLE;
          end
        end
      end
      MC_BUSY: begin
        // Branches and new starts cannot legally arrive here and are ignored.
        if (i_mc_done) begin
          state_next = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (i_br_tk) begin
          cnt_next = FL_RELOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == HZ_CNT_W'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state and extension counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_c && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  // Combinational outputs are forced to idle while reset is held.
  assign o_fwd_a     = i_rst_n ? fwd_raw[0] : FWD_RF;
  assign o_fwd_b     = i_rst_n ? fwd_raw[1] : FWD_RF;
  assign o_stall     = stall_c  && i_rst_n;
  assign o_bubble    = bubble_c && i_rst_n;
  assign o_flush     = flush_c  && i_rst_n;
  assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit with a cycle-level reference model.
module tb_hazard_ctrl_unit;

  localparam int AW    = 5;
  localparam int LL    = 3;
  localparam int FC    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    logic [AW-1:0] id_rs1, id_rs2;
    logic          id_u1, id_u2;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          ex_wr, ex_load;
    logic [AW-1:0] mem_rd;
    logic          mem_wr;
    logic [AW-1:0] wb_rd;
    logic          wb_wr;
    logic          br, mcs, mcd;
  } stim_t;

  typedef struct {
    logic [1:0]    fa, fb;
    logic          stall, bubble, flush;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_u1, id_u2, ex_wr, ex_load, mem_wr, wb_wr, br, mcs, mcd;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, bubble, flush;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  exp_t sb_q[$];

  // Reference model state: remaining extra cycles of each activity.
  int lu_left = 0;
  int fl_left = 0;
  bit mc_busy = 1'b0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .REG_AW(AW), .LOAD_LAT(LL), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
    .i_id_rs1_used(id_u1), .i_id_rs2_used(id_u2),
    .i_ex_rs1_addr(ex_rs1), .i_ex_rs2_addr(ex_rs2),
    .i_ex_rd_addr(ex_rd), .i_ex_reg_wr(ex_wr), .i_ex_is_load(ex_load),
    .i_mem_rd_addr(mem_rd), .i_mem_reg_wr(mem_wr),
    .i_wb_rd_addr(wb_rd), .i_wb_reg_wr(wb_wr),
    .i_br_tk(br), .i_mc_start(mcs), .i_mc_done(mcd),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_stall(stall), .o_bubble(bubble), .o_flush(flush),
    .o_stall_cnt(stall_cnt)
  );

  function automatic stim_t idle_stim();
    stim_t s;
    s.id_rs1 = '0; s.id_rs2 = '0; s.id_u1 = 1'b0; s.id_u2 = 1'b0;
    s.ex_rs1 = '0; s.ex_rs2 = '0; s.ex_rd = '0; s.ex_wr = 1'b0; s.ex_load = 1'b0;
    s.mem_rd = '0; s.mem_wr = 1'b0; s.wb_rd = '0; s.wb_wr = 1'b0;
    s.br = 1'b0; s.mcs = 1'b0; s.mcd = 1'b0;
    return s;
  endfunction

  // Producers listed youngest first; the first one writing the source wins.
  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [AW-1:0] src);
    logic [AW-1:0] rd [2];
    logic          wr [2];
    logic [1:0]    code [2];
    rd[0] = s.mem_rd; wr[0] = s.mem_wr; code[0] = 2'b10;
    rd[1] = s.wb_rd;  wr[1] = s.wb_wr;  code[1] = 2'b01;
    if (src == 0) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (wr[k] && rd[k] == src) return code[k];
    end
    return 2'b00;
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    bit lu;
    lu = s.ex_load && s.ex_wr && (s.ex_rd != 0) &&
         ((s.id_u1 && s.id_rs1 == s.ex_rd) || (s.id_u2 && s.id_rs2 == s.ex_rd));
    e.fa = ref_fwd(s, s.ex_rs1);
    e.fb = ref_fwd(s, s.ex_rs2);
    e.stall = 1'b0; e.bubble = 1'b0; e.flush = 1'b0;
    e.cnt = CW'(m_cnt);
    if (mc_busy) begin
      e.stall = !s.mcd;
      if (s.mcd) mc_busy = 1'b0;
    end else if (fl_left > 0) begin
      e.flush = 1'b1;
      fl_left = s.br ? FC - 1 : fl_left - 1;
    end else if (lu_left > 0) begin
      if (s.br) begin
        e.flush = 1'b1;
        lu_left = 0;
        fl_left = FC - 1;
      end else begin
        e.stall = 1'b1; e.bubble = 1'b1;
        lu_left = lu_left - 1;
      end
    end else if (s.br) begin
      e.flush = 1'b1;
      fl_left = FC - 1;
    end else if (s.mcs) begin
      e.stall = 1'b1;
      mc_busy = !s.mcd;
    end else if (lu) begin
      e.stall = 1'b1; e.bubble = 1'b1;
      lu_left = LL - 1;
    end
    if (e.stall) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
  endtask

  task automatic model_reset();
    lu_left = 0; fl_left = 0; mc_busy = 1'b0; m_cnt = 0;
  endtask

  task automatic apply(input stim_t s);
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_u1 = s.id_u1; id_u2 = s.id_u2;
    ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    ex_wr = s.ex_wr; ex_load = s.ex_load;
    mem_rd = s.mem_rd; mem_wr = s.mem_wr; wb_rd = s.wb_rd; wb_wr = s.wb_wr;
    br = s.br; mcs = s.mcs; mcd = s.mcd;
  endtask

  // One clock of stimulus; the expected response goes to the scoreboard.
  task automatic cycle(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    apply(s);
    #1;
    model_step(s, e);
    sb_q.push_back(e);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cyc++;
        vectors++;
        if (fwd_a !== e.fa || fwd_b !== e.fb || stall !== e.stall ||
            bubble !== e.bubble || flush !== e.flush || stall_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL cyc %0d: got fa=%0d fb=%0d st=%0d bu=%0d fl=%0d cnt=%0d expected fa=%0d fb=%0d st=%0d bu=%0d fl=%0d cnt=%0d",
                   cyc, fwd_a, fwd_b, stall, bubble, flush, stall_cnt,
                   e.fa, e.fb, e.stall, e.bubble, e.flush, e.cnt);
        end else begin
          $display("cyc %0d ok: fa=%0d fb=%0d st=%0d bu=%0d fl=%0d cnt=%0d",
                   cyc, fwd_a, fwd_b, stall, bubble, flush, stall_cnt);
        end
      end
    end
  end

  initial begin
    stim_t s, lu_s;

    // Reset held with hazard-looking inputs: everything must stay idle.
    s = idle_stim();
    s.br = 1'b1; s.ex_rs1 = 5'd5; s.ex_rs2 = 5'd5; s.mem_rd = 5'd5; s.mem_wr = 1'b1;
    apply(s);
    #3;
    check_val("rst_fwd_a", fwd_a, 0);
    check_val("rst_fwd_b", fwd_b, 0);
    check_val("rst_stall", stall, 0);
    check_val("rst_flush", flush, 0);
    check_val("rst_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply(idle_stim());
    model_reset();

    // Forwarding priority.
    s = idle_stim();
    s.ex_rs1 = 5'd5; s.ex_rs2 = 5'd3;
    s.mem_rd = 5'd5; s.mem_wr = 1'b1; s.wb_rd = 5'd5; s.wb_wr = 1'b1;
    cycle(s);
    s.mem_wr = 1'b0;
    cycle(s);
    s.ex_rs1 = 5'd0; s.mem_rd = 5'd0; s.mem_wr = 1'b1; s.wb_rd = 5'd0;
    cycle(s);
    s.ex_rs2 = 5'd9; s.wb_rd = 5'd9; s.mem_rd = 5'd9; s.mem_wr = 1'b0;
    cycle(s);

    // Load-use hazard and the unused-source case.
    lu_s = idle_stim();
    lu_s.ex_load = 1'b1; lu_s.ex_wr = 1'b1; lu_s.ex_rd = 5'd7;
    lu_s.id_rs2 = 5'd7; lu_s.id_u2 = 1'b1;
    cycle(lu_s);
    repeat (4) cycle(idle_stim());
    s = lu_s; s.id_u2 = 1'b0;
    cycle(s);
    cycle(idle_stim());

    // Taken branch, then back-to-back branches extending the flush.
    s = idle_stim(); s.br = 1'b1;
    cycle(s);
    repeat (3) cycle(idle_stim());
    cycle(s);
    cycle(s);
    repeat (3) cycle(idle_stim());

    // Branch in the second cycle of a load-use stall.
    cycle(lu_s);
    cycle(s);
    repeat (4) cycle(idle_stim());

    // Asynchronous reset while a multi-cycle op is busy.
    s = idle_stim(); s.mcs = 1'b1;
    cycle(s);
    repeat (2) cycle(idle_stim());
    @(posedge clk); #1;
    s = idle_stim(); s.br = 1'b1; s.ex_rs1 = 5'd4; s.mem_rd = 5'd4; s.mem_wr = 1'b1;
    apply(s);
    #1;
    check_val("mc_busy_stall", stall, 1);
    check_val("mc_busy_flush", flush, 0);
    rst_n = 1'b0;
    #1;
    check_val("arst_stall", stall, 0);
    check_val("arst_flush", flush, 0);
    check_val("arst_fwd_a", fwd_a, 0);
    check_val("arst_cnt", stall_cnt, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    apply(idle_stim());
    model_reset();

    // Multi-cycle op: start, four busy cycles, done.
    s = idle_stim(); s.mcs = 1'b1;
    cycle(s);
    repeat (4) cycle(idle_stim());
    s = idle_stim(); s.mcd = 1'b1;
    cycle(s);
    cycle(idle_stim());
    check_val("mc_stall_cnt", stall_cnt, 5);

    // Saturation: 21 more stall cycles on a 4-bit counter.
    repeat (7) begin
      cycle(lu_s);
      repeat (3) cycle(idle_stim());
    end
    check_val("sat_cnt", stall_cnt, CMAX);

    // Randomised traffic over a small register set for frequent hits.
    for (int n = 0; n < 400; n++) begin
      s.id_rs1 = AW'($urandom_range(0, 7));
      s.id_rs2 = AW'($urandom_range(0, 7));
      s.id_u1 = 1'($urandom_range(0, 1));
      s.id_u2 = 1'($urandom_range(0, 1));
      s.ex_rs1 = AW'($urandom_range(0, 7));
      s.ex_rs2 = AW'($urandom_range(0, 7));
      s.ex_rd = AW'($urandom_range(0, 7));
      s.ex_wr = 1'($urandom_range(0, 1));
      s.ex_load = ($urandom_range(0, 2) == 0);
      s.mem_rd = AW'($urandom_range(0, 7));
      s.mem_wr = 1'($urandom_range(0, 1));
      s.wb_rd = AW'($urandom_range(0, 7));
      s.wb_wr = 1'($urandom_range(0, 1));
      s.br = ($urandom_range(0, 9) == 0) && !mc_busy;
      s.mcs = !mc_busy && ($urandom_range(0, 11) == 0);
      if (mc_busy) s.mcd = ($urandom_range(0, 3) == 0);
      else s.mcd = s.mcs && ($urandom_range(0, 4) == 0);
      cycle(s);
    end
    cycle(idle_stim());

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
